mult_ctrl: RTL and testbench

MULT_CTRL -- requirements
Module: mult_ctrl

---
 rtl/mult_ctrl_if.sv | 34 +++
 rtl/mult_ctrl.sv | 130 +++++++++++++
 tb/tb_mult_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mult_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_ctrl_if
//  Description : Handshake between the add/shift multiplier controller and
//                its datapath (start request, multiplier LSB, control strobes
//                and iteration count).
//  Revision    : 1.0  initial release
// ============================================================================
interface mult_ctrl_if #(
    parameter int CW = 4
);
    logic          i_start;
    logic          i_lsb;
    logic          o_load;
    logic          o_add;
    logic          o_sub;
    logic          o_shift;
    logic          o_busy;
    logic          o_done;
    logic [CW-1:0] o_count;

    // Controller side
    modport slave (
        input  i_start, i_lsb,
        output o_load, o_add, o_sub, o_shift, o_busy, o_done, o_count
    );

    // Datapath / requester side
    modport master (
        output i_start, i_lsb,
        input  o_load, o_add, o_sub, o_shift, o_busy, o_done, o_count
    );
endinterface
`default_nettype wire

// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult_ctrl
//  Description : Control FSM for a shift/add multiplier. IDLE -> LOAD -> CALC
//                (DW iterations) -> DONE. Start is taken on a rising edge of
//                i_start only.
//                Optional macro SIGNED_MODE_EN: final CALC iteration subtracts
//                the multiplicand (two's-complement multiplier weight).
//  Revision    : 1.0  initial release
// ============================================================================
module mult_ctrl #(
    parameter int DW = 9,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mult_ctrl_if.slave   bus
);

    localparam logic [1:0]    C_IDLE = 2'd0;
    localparam logic [1:0]    C_LOAD = 2'd1;
    localparam logic [1:0]    C_CALC = 2'd2;
    localparam logic [1:0]    C_DONE = 2'd3;
    localparam logic [CW-1:0] C_LAST = CW'(DW - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          start_prev_q;

    logic          w_start_edge;
    logic          w_last;
    logic          w_load, w_add, w_sub, w_shift, w_busy, w_done;

    assign w_start_edge = bus.i_start & ~start_prev_q;
    assign w_last       = (count_q == C_LAST);

    // Start history; resets high so a level already present at reset
    // release is not mistaken for a new request.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            start_prev_q <= 1'b1;
        end else begin
            start_prev_q <= bus.i_start;
        end
    end

    // State and iteration counter registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= C_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; edges outside IDLE are simply not looked at
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            C_IDLE: begin
                if (w_start_edge) begin
                    state_d = C_LOAD;
                end
            end
            C_LOAD: begin
                count_d = '0;
                state_d = C_CALC;
            end
            C_CALC: begin
                count_d = count_q + CW'(1);
                if (w_last) begin
                    state_d = C_DONE;
                end
            end
            C_DONE: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        w_load  = 1'b0;
        w_add   = 1'b0;
        w_sub   = 1'b0;
        w_shift = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (state_q)
            C_LOAD: begin
                w_load = 1'b1;
                w_busy = 1'b1;
            end
            C_CALC: begin
                w_shift = 1'b1;
                w_busy  = 1'b1;
`ifdef SIGNED_MODE_EN
                // The multiplier MSB carries negative weight
                w_add = bus.i_lsb & ~w_last;
                w_sub = bus.i_lsb &  w_last;
`else
                w_add = bus.i_lsb;
                w_sub = 1'b0;
`endif
            end
            C_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    assign bus.o_load  = w_load;
    assign bus.o_add   = w_add;
    assign bus.o_sub   = w_sub;
    assign bus.o_shift = w_shift;
    assign bus.o_busy  = w_busy;
    assign bus.o_done  = w_done;
    assign bus.o_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_ctrl
//  Description : Directed self-checking bench for mult_ctrl with a small
//                shift/add datapath model driving i_lsb and forming the product.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_ctrl;

    localparam int DW = 9;
    localparam int CW = $clog2(DW + 1);
`ifdef SIGNED_MODE_EN
    localparam bit SIGNED = 1'b1;
`else
    localparam bit SIGNED = 1'b0;
`endif

    logic clk;
    logic rst;

    mult_ctrl_if #(.CW(CW)) bus ();

    mult_ctrl #(.DW(DW), .CW(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Datapath model: accumulator with guard bit, multiplier shift register
    logic [8:0] m_mplier = '0;
    logic [8:0] m_mcand  = '0;
    logic [9:0] acc      = '0;
    logic [8:0] mq       = '0;
    logic [9:0] mc_ext;
    logic [9:0] t;

    assign mc_ext     = SIGNED ? {m_mcand[8], m_mcand} : {1'b0, m_mcand};
    assign bus.i_lsb  = mq[0];

    always @(posedge clk) begin
        if (bus.o_load) begin
            acc <= '0;
            mq  <= m_mplier;
        end else if (bus.o_shift) begin
            t = acc;
            if (bus.o_add) t = t + mc_ext;
            if (bus.o_sub) t = t - mc_ext;
            mq  <= {t[0], mq[8:1]};
            acc <= SIGNED ? {t[9], t[9:1]} : {1'b0, t[9:1]};
        end
    end

    logic [5:0]  ctrl;
    logic [17:0] product;
    assign ctrl    = {bus.o_load, bus.o_add, bus.o_sub, bus.o_shift, bus.o_busy, bus.o_done};
    assign product = {acc[8:0], mq};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One full operation. Entered at a negedge in IDLE with i_start low.
    // pulse_at: CALC iteration during which i_start is pulsed (-1: none).
    task automatic run_op(input string tag, input logic [8:0] mpl, input logic [8:0] mcd,
                          input logic [17:0] exp_prod, input int pulse_at, input bit keep_high);
        logic e_last, e_add, e_sub;
        m_mplier    = mpl;
        m_mcand     = mcd;
        bus.i_start = 1'b1;
        tick();
        chk({tag, ".load"}, ctrl, 6'b100010);
        if (!keep_high) bus.i_start = (pulse_at == 0);
        for (int i = 0; i < DW; i++) begin
            tick();
            e_last = (i == DW - 1);
            e_add  = mpl[i] & ~(SIGNED & e_last);
            e_sub  = mpl[i] &  (SIGNED & e_last);
            chk($sformatf("%s.calc%0d", tag, i), ctrl, {1'b0, e_add, e_sub, 3'b110});
            chk($sformatf("%s.count%0d", tag, i), bus.o_count, i);
            if (!keep_high) bus.i_start = (i + 1 == pulse_at);
        end
        tick();
        chk({tag, ".done"}, ctrl, 6'b000001);
        chk({tag, ".done_count"}, bus.o_count, DW);
        chk({tag, ".product"}, product, exp_prod);
        tick();
        chk({tag, ".idle"}, ctrl, 6'b000000);
        chk({tag, ".idle_count"}, bus.o_count, DW);
    endtask

    int done_seen;
    int busy_seen;

    initial begin
        rst         = 1'b0;
        bus.i_start = 1'b0;
        tick();
        tick();
        chk("reset.ctrl", ctrl, 6'b000000);
        chk("reset.count", bus.o_count, 0);
        rst = 1'b1;
        tick();
        chk("post_reset.ctrl", ctrl, 6'b000000);

        // Basic operation, 11 * 3
        run_op("op_0b", 9'h00B, 9'h003, 18'd33, -1, 1'b0);

        // Level held high: exactly one operation
        run_op("hold", 9'h00B, 9'h003, 18'd33, -1, 1'b1);
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 28; i++) begin
            tick();
            if (bus.o_done) done_seen++;
            if (bus.o_busy) busy_seen++;
        end
        chk("hold.extra_done", done_seen, 0);
        chk("hold.extra_busy", busy_seen, 0);
        bus.i_start = 1'b0;
        tick();
        run_op("second", 9'h155, 9'h007, SIGNED ? 18'h3FB53 : 18'd2387, -1, 1'b0);

        // Start pulse during CALC iteration 4 is ignored
        run_op("ignore", 9'h0A6, 9'h005, 18'd830, 4, 1'b0);
        tick();
        chk("ignore.no_load", ctrl, 6'b000000);

        // Reset during CALC iteration 5 with start held at release
        m_mplier    = 9'h0FF;
        m_mcand     = 9'h001;
        bus.i_start = 1'b1;
        tick();
        chk("rst_mid.load", ctrl, 6'b100010);
        bus.i_start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rst_mid.iter5", bus.o_count, 5);
        rst         = 1'b0;
        bus.i_start = 1'b1;
        #1;
        chk("rst_mid.ctrl", ctrl, 6'b000000);
        chk("rst_mid.count", bus.o_count, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_mid.stay_idle%0d", i), ctrl, 6'b000000);
        end
        bus.i_start = 1'b0;
        tick();
        chk("rst_mid.still_idle", ctrl, 6'b000000);

        // All-ones multiplier: -1 * 3 signed, 511 * 3 unsigned
        run_op("ones", 9'h1FF, 9'h003, SIGNED ? 18'h3FFFD : 18'd1533, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
